// File: rtl/dcache_pkg.sv
// ---------------------------------------------------------------------------
// dcache_pkg : shared types, reqtag encodings and address helpers
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package dcache_pkg;

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    LOOKUP    = 3'd1,
    FILL_REQ  = 3'd2,
    FILL_WAIT = 3'd3,
    RESPOND   = 3'd4
  } state_e;

  // reqtag = {rw, type[3:0], kind, pad}; pad fills the remaining low bits
  localparam int        RT_FIELDS_W = 6;
  localparam logic      RW_READ     = 1'b0;
  localparam logic      RW_WRITE    = 1'b1;
  localparam logic [3:0] TYPE_MEMORY = 4'd1;
  localparam logic      KIND_DATA   = 1'b1;

  function automatic logic [63:0] line_base(input logic [63:0] addr, input int off_w);
    return (addr >> off_w) << off_w;
  endfunction

  function automatic logic tag_is_write(input logic rw_bit);
    return rw_bit == RW_WRITE;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dcache_line_store.sv
// ---------------------------------------------------------------------------
// dcache_line_store : valid/tag arrays and line data RAM, 1 write + 1 read port
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_line_store #(
  parameter  int LINES      = 64,
  parameter  int LINE_BEATS = 8,
  parameter  int TAGA_W     = 52,
  localparam int IDX_W      = $clog2(LINES),
  localparam int BEAT_W     = $clog2(LINE_BEATS)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              wr_en_i,
  input  logic [IDX_W-1:0]  wr_idx_i,
  input  logic [BEAT_W-1:0] wr_beat_i,
  input  logic [63:0]       wr_data_i,
  input  logic              set_valid_i,
  input  logic [TAGA_W-1:0] set_tag_i,
  input  logic              inv_i,
  input  logic [IDX_W-1:0]  rd_idx_i,
  input  logic [BEAT_W-1:0] rd_beat_i,
  output logic              rd_valid_o,
  output logic [TAGA_W-1:0] rd_tag_o,
  output logic [63:0]       rd_data_o
);

  logic [LINES-1:0]  valid_q;
  logic [TAGA_W-1:0] tag_q  [LINES];
  logic [63:0]       data_q [LINES*LINE_BEATS];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= '0;
    end else if (set_valid_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end else if (inv_i) begin
      valid_q[wr_idx_i] <= 1'b0;
    end
  end

  // Tag and data need no reset: valid_q gates every use of them.
  always_ff @(posedge clk) begin
    if (set_valid_i) tag_q[wr_idx_i] <= set_tag_i;
    if (wr_en_i)     data_q[{wr_idx_i, wr_beat_i}] <= wr_data_i;
  end

  assign rd_valid_o = valid_q[rd_idx_i];
  assign rd_tag_o   = tag_q[rd_idx_i];
  assign rd_data_o  = data_q[{rd_idx_i, rd_beat_i}];

endmodule

`default_nettype wire

// File: rtl/dcache_read_responder.sv
// ---------------------------------------------------------------------------
// dcache_read_responder : core-side read responder with line fill on miss
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module dcache_read_responder
  import dcache_pkg::*;
#(
  parameter int LINES      = 64,
  parameter int LINE_BEATS = 8,
  parameter int TAG_W      = 13
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             core_reqcyc,
  input  logic [63:0]      core_req,
  input  logic [TAG_W-1:0] core_reqtag,
  output logic             core_reqack,
  output logic             core_respcyc,
  output logic [63:0]      core_resp,
  output logic [TAG_W-1:0] core_resptag,
  input  logic             core_respack,
  output logic             mem_reqcyc,
  output logic [63:0]      mem_req,
  output logic [TAG_W-1:0] mem_reqtag,
  input  logic             mem_reqack,
  input  logic             mem_respcyc,
  input  logic [63:0]      mem_resp,
  output logic             mem_respack
);

  localparam int BEAT_W  = $clog2(LINE_BEATS);
  localparam int OFF_W   = BEAT_W + 3;
  localparam int IDX_W   = $clog2(LINES);
  localparam int TAGA_W  = 64 - OFF_W - IDX_W;
  localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(LINE_BEATS - 1);

  state_e            state_q, state_d;
  logic [63:0]       addr_q;
  logic [TAG_W-1:0]  rtag_q;
  logic [BEAT_W-1:0] beat_q;
  logic [63:0]       resp_q;

  logic [IDX_W-1:0]  w_idx;
  logic [BEAT_W-1:0] w_word;
  logic [TAGA_W-1:0] w_tag;
  logic              w_is_write;
  logic              w_rd_valid;
  logic [TAGA_W-1:0] w_rd_tag;
  logic [63:0]       w_rd_data;
  logic              w_hit;
  logic              w_beat_take;
  logic [BEAT_W-1:0] w_beat_num;
  logic              w_beat_last;
  logic [TAG_W-1:0]  w_mem_tag;

  assign w_idx      = addr_q[OFF_W +: IDX_W];
  assign w_word     = addr_q[3 +: BEAT_W];
  assign w_tag      = addr_q[63 -: TAGA_W];
  assign w_is_write = tag_is_write(rtag_q[TAG_W-1]);
  assign w_hit      = w_rd_valid && (w_rd_tag == w_tag);
  assign w_mem_tag  = {RW_READ, TYPE_MEMORY, KIND_DATA, {(TAG_W-RT_FIELDS_W){1'b0}}};

  // A beat presented together with the request ack counts as beat 0.
  assign w_beat_take = mem_respcyc &&
                       ((state_q == FILL_WAIT) || (state_q == FILL_REQ && mem_reqack));
  assign w_beat_num  = (state_q == FILL_REQ) ? '0 : beat_q;
  assign w_beat_last = w_beat_take && (w_beat_num == LAST_BEAT);

  dcache_line_store #(
    .LINES      (LINES),
    .LINE_BEATS (LINE_BEATS),
    .TAGA_W     (TAGA_W)
  ) u_store (
    .clk         (clk),
    .reset       (reset),
    .wr_en_i     (w_beat_take),
    .wr_idx_i    (w_idx),
    .wr_beat_i   (w_beat_num),
    .wr_data_i   (mem_resp),
    .set_valid_i (w_beat_last),
    .set_tag_i   (w_tag),
    .inv_i       (state_q == LOOKUP && w_is_write && w_hit),
    .rd_idx_i    (w_idx),
    .rd_beat_i   (w_word),
    .rd_valid_o  (w_rd_valid),
    .rd_tag_o    (w_rd_tag),
    .rd_data_o   (w_rd_data)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (core_reqcyc) state_d = LOOKUP;
      LOOKUP:    state_d = (w_is_write || w_hit) ? RESPOND : FILL_REQ;
      FILL_REQ:  if (mem_reqack) state_d = w_beat_last ? RESPOND : FILL_WAIT;
      FILL_WAIT: if (w_beat_last) state_d = RESPOND;
      RESPOND:   if (core_respack) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q <= '0;
      rtag_q <= '0;
      beat_q <= '0;
      resp_q <= '0;
    end else begin
      if (state_q == IDLE && core_reqcyc) begin
        addr_q <= core_req;
        rtag_q <= core_reqtag;
      end
      if (state_q == LOOKUP) resp_q <= w_is_write ? '0 : w_rd_data;
      // The requested word is captured straight off the fill bus.
      if (w_beat_take) begin
        beat_q <= w_beat_num + BEAT_W'(1);
        if (w_beat_num == w_word) resp_q <= mem_resp;
      end else if (state_q == FILL_REQ && mem_reqack) begin
        beat_q <= '0;
      end
    end
  end

  always_comb begin
    core_reqack  = 1'b0;
    core_respcyc = 1'b0;
    core_resp    = '0;
    core_resptag = '0;
    mem_reqcyc   = 1'b0;
    mem_req      = '0;
    mem_reqtag   = '0;
    mem_respack  = w_beat_take;
    case (state_q)
      IDLE: core_reqack = core_reqcyc && reset;
      RESPOND: begin
        core_respcyc = 1'b1;
        core_resp    = resp_q;
        core_resptag = rtag_q;
      end
      FILL_REQ: begin
        mem_reqcyc = 1'b1;
        mem_req    = line_base(addr_q, OFF_W);
        mem_reqtag = w_mem_tag;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_dcache_read_responder.sv
// ---------------------------------------------------------------------------
// tb_dcache_read_responder : vector-table bench with a simple fill-bus model
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_dcache_read_responder;

  localparam logic [12:0] RT = 13'h0180;  // read, memory, data
  localparam logic [12:0] WT = 13'h1180;  // write, memory, data

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        core_reqcyc = 1'b0;
  logic [63:0] core_req = '0;
  logic [12:0] core_reqtag = '0;
  logic        core_reqack;
  logic        core_respcyc;
  logic [63:0] core_resp;
  logic [12:0] core_resptag;
  logic        core_respack = 1'b0;
  logic        mem_reqcyc;
  logic [63:0] mem_req;
  logic [12:0] mem_reqtag;
  logic        mem_reqack = 1'b0;
  logic        mem_respcyc = 1'b0;
  logic [63:0] mem_resp = '0;
  logic        mem_respack;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dcache_read_responder #(.LINES(64), .LINE_BEATS(8), .TAG_W(13)) dut (
    .clk          (clk),
    .reset        (reset),
    .core_reqcyc  (core_reqcyc),
    .core_req     (core_req),
    .core_reqtag  (core_reqtag),
    .core_reqack  (core_reqack),
    .core_respcyc (core_respcyc),
    .core_resp    (core_resp),
    .core_resptag (core_resptag),
    .core_respack (core_respack),
    .mem_reqcyc   (mem_reqcyc),
    .mem_req      (mem_req),
    .mem_reqtag   (mem_reqtag),
    .mem_reqack   (mem_reqack),
    .mem_respcyc  (mem_respcyc),
    .mem_resp     (mem_resp),
    .mem_respack  (mem_respack)
  );

  typedef struct {
    logic [63:0] addr;
    logic [12:0] tag;
    bit          miss;   // a line fill is expected
    logic [63:0] fbase;  // fill beat k carries fbase + k
    logic [63:0] exp;
    int          hold;   // cycles core_respack stays low
    bit          ov;     // first beat arrives with mem_reqack
    bit          keep;   // core keeps core_reqcyc high throughout
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic run_req(input vec_t v, input string nm);
    int  beat = 0;
    int  rcnt = 0;
    bit  feeding = 0, saw_req = 0, ack_out = 0, done = 0;
    int  exp_lat;
    exp_lat = !v.miss ? 2 : (v.ov ? 10 : 11);
    @(negedge clk);
    core_reqcyc = 1'b1;
    core_req    = v.addr;
    core_reqtag = v.tag;
    #1 chk({nm, "_reqack"}, core_reqack, 1);
    @(posedge clk);
    #1;
    if (!v.keep) core_reqcyc = 1'b0;
    for (int k = 1; k <= 60 && !done; k++) begin
      @(negedge clk);
      if (ack_out) begin
        chk({nm, "_resp_drop"}, core_respcyc, 0);
        core_respack = 1'b0;
        done = 1;
      end else begin
        if (v.keep) chk({nm, "_no_reack"}, core_reqack, 0);
        mem_reqack  = 1'b0;
        mem_respcyc = 1'b0;
        if (mem_reqcyc) begin
          if (!saw_req) begin
            chk({nm, "_mem_req"}, mem_req, v.addr & ~64'h3f);
            chk({nm, "_mem_reqtag"}, mem_reqtag, RT);
          end
          saw_req = 1;
          feeding = 1;
          mem_reqack = 1'b1;
          if (v.ov) begin
            mem_respcyc = 1'b1;
            mem_resp    = v.fbase;
            beat        = 1;
          end
        end else if (feeding && beat < 8) begin
          mem_respcyc = 1'b1;
          mem_resp    = v.fbase + 64'(beat);
          beat++;
        end
        if (core_respcyc) begin
          if (rcnt == 0) begin
            chk({nm, "_latency"}, 64'(k), 64'(exp_lat));
            chk({nm, "_resp"}, core_resp, v.exp);
            chk({nm, "_resptag"}, core_resptag, v.tag);
          end else begin
            chk({nm, "_resp_stable"}, core_resp, v.exp);
          end
          if (rcnt == v.hold) begin
            core_respack = 1'b1;
            core_reqcyc  = 1'b0;
            ack_out      = 1;
          end
          rcnt++;
        end
        #1;
        if (mem_respcyc) chk({nm, "_mem_respack"}, mem_respack, 1);
      end
    end
    mem_reqack   = 1'b0;
    mem_respcyc  = 1'b0;
    core_reqcyc  = 1'b0;
    core_respack = 1'b0;
    if (!done) chk({nm, "_timeout"}, 0, 1);
    chk({nm, "_fill_issued"}, 64'(saw_req), 64'(v.miss));
  endtask

  initial begin
    vecs[0]  = '{64'h1008, RT, 1'b1, 64'hA0, 64'hA1, 0, 1'b0, 1'b0};  // cold miss
    vecs[1]  = '{64'h1038, RT, 1'b0, 64'h0,  64'hA7, 0, 1'b0, 1'b1};  // hit, last word
    vecs[2]  = '{64'h1000, RT, 1'b0, 64'h0,  64'hA0, 5, 1'b0, 1'b0};  // slow respack
    vecs[3]  = '{64'h2010, RT, 1'b1, 64'hB0, 64'hB2, 0, 1'b1, 1'b0};  // conflict, overlap
    vecs[4]  = '{64'h1008, RT, 1'b1, 64'hC0, 64'hC1, 0, 1'b0, 1'b1};  // evicted again
    vecs[5]  = '{64'h1078, RT, 1'b1, 64'hD0, 64'hD7, 0, 1'b0, 1'b0};  // word = last beat
    vecs[6]  = '{64'h1000, WT, 1'b0, 64'h0,  64'h0,  0, 1'b0, 1'b0};  // write hit
    vecs[7]  = '{64'h1000, RT, 1'b1, 64'hE0, 64'hE0, 0, 1'b0, 1'b0};  // invalidated
    vecs[8]  = '{64'h5040, WT, 1'b0, 64'h0,  64'h0,  0, 1'b0, 1'b0};  // write miss
    vecs[9]  = '{64'h1078, RT, 1'b0, 64'h0,  64'hD7, 0, 1'b0, 1'b0};  // line 1 intact
    vecs[10] = '{64'h1040, RT, 1'b0, 64'h0,  64'hD0, 2, 1'b0, 1'b0};

    // Reset with a request pending: nothing may leak out.
    core_reqcyc = 1'b1;
    core_req    = 64'h1008;
    core_reqtag = RT;
    repeat (2) @(negedge clk);
    chk("reset_ctl", {60'b0, core_reqack, core_respcyc, mem_reqcyc, mem_respack}, 0);
    chk("reset_data", core_resp | mem_req, 0);
    chk("reset_tags", {core_resptag, mem_reqtag}, 0);
    core_reqcyc = 1'b0;
    reset = 1'b1;

    for (int i = 0; i < 11; i++) run_req(vecs[i], $sformatf("v%0d", i));

    // Reset during beat 3 of a fill, then refetch.
    @(negedge clk);
    core_reqcyc = 1'b1;
    core_req    = 64'h3000;
    core_reqtag = RT;
    @(posedge clk);
    #1 core_reqcyc = 1'b0;
    for (int k = 0; k < 20 && !mem_reqcyc; k++) @(negedge clk);
    chk("rst_fill_req", mem_reqcyc, 1);
    mem_reqack = 1'b1;
    @(negedge clk);
    mem_reqack = 1'b0;
    for (int b = 0; b < 3; b++) begin
      mem_respcyc = 1'b1;
      mem_resp    = 64'h90 + 64'(b);
      @(negedge clk);
    end
    mem_resp = 64'h93;
    #1 chk("rst_beat3_ack", mem_respack, 1);
    #1 reset = 1'b0;
    #1;
    chk("rst_mid_ctl", {60'b0, core_reqack, core_respcyc, mem_reqcyc, mem_respack}, 0);
    chk("rst_mid_data", core_resp | mem_req, 0);
    chk("rst_mid_tags", {core_resptag, mem_reqtag}, 0);
    @(negedge clk);
    mem_resp = 64'h94;
    reset = 1'b1;
    for (int b = 5; b < 8; b++) begin
      @(negedge clk);
      mem_resp = 64'h90 + 64'(b);
      #1 chk("rst_stray_beat", {62'b0, mem_respack, core_respcyc}, 0);
    end
    mem_respcyc = 1'b0;

    run_req('{64'h3000, RT, 1'b1, 64'hF0, 64'hF0, 0, 1'b0, 1'b0}, "post_rst_same");
    run_req('{64'h1078, RT, 1'b1, 64'h70, 64'h77, 0, 1'b0, 1'b0}, "post_rst_other");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/dcache_read_responder.md
Name: dcache_read_responder

Overview:
- Responder (cache-side) end of the core data-cache request/response handshake; the core's memory stage is the initiator.
- Accepts one core read request at a time, looks it up in a small direct-mapped line store, and returns one 64-bit word.
- On a miss, fetches the whole line from the downstream memory bus using the same handshake, acting as initiator there, then responds to the core.
- Sits between the pipeline memory stage and the memory/arbiter bus.

Parameters:
- LINES, 64, number of direct-mapped lines (power of 2).
- LINE_BEATS, 8, 64-bit beats per line (line = LINE_BEATS*8 bytes).
- TAG_W, 13, width of the reqtag field.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous reset, active-low.
- core_reqcyc  in  1  core request valid.
- core_req  in  64  byte address.
- core_reqtag  in  TAG_W  {rw, type, kind, 7'b0}.
- core_reqack  out  1  one-cycle request-accept pulse.
- core_respcyc  out  1  response valid.
- core_resp  out  64  read data.
- core_resptag  out  TAG_W  echo of the accepted reqtag.
- core_respack  in  1  core consumed the response.
- mem_reqcyc  out  1  downstream request valid.
- mem_req  out  64  line-aligned address.
- mem_reqtag  out  TAG_W  {READ, MEMORY, DATA, 7'b0}.
- mem_reqack  in  1  downstream accepted.
- mem_respcyc  in  1  fill beat valid.
- mem_resp  in  64  fill beat data.
- mem_respack  out  1  beat consumed.

Behaviour:
- Reset (asynchronous, reset==0):
  - All valid bits cleared; state IDLE.
  - Every output driven to 0: core_reqack, core_respcyc, core_resp, core_resptag, mem_reqcyc, mem_req, mem_reqtag, mem_respack.
  - Reset mid-fill abandons the fill; beats arriving after reset release are ignored, mem_respack stays 0 while IDLE.
- Address split:
  - offset = log2(LINE_BEATS*8) low bits; word = req[.. beat index].
  - index = log2(LINES) bits above offset; tag = remaining upper bits.
- IDLE: on core_reqcyc==1, capture req/reqtag, pulse core_reqack for exactly 1 cycle, go to LOOKUP. core_reqack is never asserted in any other state.
- LOOKUP (1 cycle):
  - valid[index] && tag match -> RESPOND.
  - Otherwise -> FILL_REQ.
  - A WRITE-tagged request clears valid[index] on match, then goes to RESPOND with core_resp=0 (no fill).
- RESPOND:
  - core_respcyc=1, core_resp=line[index][word], core_resptag=captured tag.
  - Held stable until core_respack==1 is sampled, then deasserted next cycle, -> IDLE.
- Hit latency: request sampled cycle N, core_respcyc high at N+2.
- FILL_REQ:
  - mem_reqcyc=1, mem_req=addr with offset bits zeroed, mem_reqtag={READ,MEMORY,DATA,7'b0}.
  - Held until mem_reqack sampled, then deasserted -> FILL_WAIT, beat counter=0.
- FILL_WAIT:
  - mem_respack = mem_respcyc (combinational; each beat consumed the cycle it is presented).
  - Beat k written to line[index][k]; counter increments, wraps at LINE_BEATS.
  - On the last beat: tag[index] and valid[index] set -> RESPOND.
  - The word for the core is forwarded from the fill buffer, so a word == last-beat case returns the correct data.
- Simultaneous mem_reqack and mem_respcyc in the same cycle: the beat is accepted as beat 0.
- Only one outstanding core request; core_reqcyc held by the core during the transaction is not re-accepted until IDLE.

Decomposition:
- Package dcache_pkg:
  - state enum {IDLE, LOOKUP, FILL_REQ, FILL_WAIT, RESPOND}.
  - Reqtag field positions and constants READ/WRITE, MEMORY, DATA.
  - Address slice helper functions.
- Sub-module dcache_line_store: valid/tag arrays plus data RAM, with one write port (fill/invalidate) and one read port. It is the natural split for later SRAM replacement.

Test Plan:
- Cold read 0x1008 -> core_reqack at N+0; mem_req=0x1000 on mem_reqcyc; 8 beats 0xA0..0xA7 fed; core_resp=0xA1, resptag echoed.
- Repeat read 0x1038 after the fill -> hit, no mem_reqcyc, core_respcyc at N+2, core_resp=0xA7.
- Conflict read 0x1000+LINES*64 -> miss, refill, then re-read 0x1008 misses again.
- core_respack held low for 5 cycles -> core_respcyc and core_resp stay stable for all 5 cycles; deasserted the cycle after ack.
- WRITE-tagged 0x1000 after a hit -> core_resp=0, and the subsequent read 0x1000 issues mem_reqcyc.
- reset pulled low at beat 3 of a fill -> all outputs 0 immediately; next read of the same line misses and refetches.
